// File: rtl/uart_rx_cmd_parser.sv
// Drains the uart rx FIFO, hunts for the EB 90 header and decodes fixed-length command frames
// (CMD, 4 data bytes, additive checksum) into a one-cycle command strobe.
module uart_rx_cmd_parser #(
    parameter logic [7:0]  HDR0    = 8'hEB,
    parameter logic [7:0]  HDR1    = 8'h90,
    parameter int unsigned TIMEOUT = 110592,
    parameter int unsigned TO_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_ren,
    input  logic [7:0]  rx_fifo_rdata,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_data,
    output logic        chk_err,
    output logic        to_err,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {StHunt0, StHunt1, StCmd, StData, StSum} state_e;

    localparam logic [TO_W-1:0] TermCnt = TO_W'(TIMEOUT - 1);

    state_e           state;
    logic             byte_vld;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       idx;
    logic [7:0]       sum;
    logic [7:0]       cmd_r;
    logic [31:0]      data_r;
    logic             timeout;

    // A read is pending while byte_vld is high, so reads are spaced at least two cycles apart.
    assign rx_fifo_ren = rst & ~rx_fifo_empty & ~byte_vld;
    assign busy        = (state != StHunt0);
    // to_cnt counts the byte_vld cycle as 0, so the strobe lands TIMEOUT cycles after it.
    assign timeout     = (state != StHunt0) && !byte_vld && (to_cnt == TermCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StHunt0;
            byte_vld  <= 1'b0;
            to_cnt    <= '0;
            idx       <= 2'd0;
            sum       <= 8'd0;
            cmd_r     <= 8'd0;
            data_r    <= 32'd0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'd0;
            cmd_data  <= 32'd0;
            chk_err   <= 1'b0;
            to_err    <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            byte_vld  <= rx_fifo_ren;
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            to_err    <= 1'b0;

            if (timeout) begin
                to_err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                state  <= StHunt0;
                to_cnt <= '0;
            end else if (byte_vld) begin
                to_cnt <= TO_W'(1);
                unique case (state)
                    StHunt0: begin
                        if (rx_fifo_rdata == HDR0) state <= StHunt1;
                        else to_cnt <= '0;
                    end
                    StHunt1: begin
                        if (rx_fifo_rdata == HDR1) begin
                            state <= StCmd;
                        end else if (rx_fifo_rdata != HDR0) begin
                            state  <= StHunt0;
                            to_cnt <= '0;
                        end
                    end
                    StCmd: begin
                        cmd_r <= rx_fifo_rdata;
                        sum   <= rx_fifo_rdata;
                        idx   <= 2'd0;
                        state <= StData;
                    end
                    StData: begin
                        data_r <= {data_r[23:0], rx_fifo_rdata};
                        sum    <= sum + rx_fifo_rdata;
                        idx    <= idx + 2'd1;
                        if (idx == 2'd3) state <= StSum;
                    end
                    StSum: begin
                        if (rx_fifo_rdata == sum) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= cmd_r;
                            cmd_data  <= data_r;
                        end else begin
                            chk_err <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                        state  <= StHunt0;
                        to_cnt <= '0;
                    end
                    default: begin
                        state  <= StHunt0;
                        to_cnt <= '0;
                    end
                endcase
            end else if (state == StHunt0) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser: table of frames plus hand-written timeout,
// saturation and mid-frame reset sequences against a simple FIFO model.
module tb_uart_rx_cmd_parser;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_fifo_empty;
    logic        rx_fifo_ren;
    logic [7:0]  rx_fifo_rdata;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        chk_err;
    logic        to_err;
    logic [7:0]  err_cnt;
    logic        busy;

    uart_rx_cmd_parser #(
        .HDR0    (8'hEB),
        .HDR1    (8'h90),
        .TIMEOUT (TO),
        .TO_W    (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_ren   (rx_fifo_ren),
        .rx_fifo_rdata (rx_fifo_rdata),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .cmd_data      (cmd_data),
        .chk_err       (chk_err),
        .to_err        (to_err),
        .err_cnt       (err_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: bench pushes, the read side pops on rx_fifo_ren.
    logic [7:0] src [512];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    assign rx_fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_fifo_ren) begin
            rx_fifo_rdata <= src[rd_ptr[8:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Event monitor, sampled on the falling edge.
    int n_valid = 0, n_chk = 0, n_to = 0, hs_bad = 0;
    int last_ren_cyc = 0, to_cyc = 0;
    logic ren_prev = 1'b0;
    logic [7:0]  v_code = 8'd0;
    logic [31:0] v_data = 32'd0;

    always @(negedge clk) begin
        if (rx_fifo_ren && rx_fifo_empty) hs_bad++;
        if (rx_fifo_ren && ren_prev) hs_bad++;
        ren_prev = rx_fifo_ren;
        if (rx_fifo_ren) last_ren_cyc = cyc;
        if (cmd_valid) begin
            n_valid++;
            v_code = cmd_code;
            v_data = cmd_data;
        end
        if (chk_err) n_chk++;
        if (to_err) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        src[wr_ptr[8:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (rd_ptr != wr_ptr && k < 200) begin
            step();
            k++;
        end
        check({name, " drain"}, 64'(rd_ptr == wr_ptr), 64'd1);
        repeat (4) step();
    endtask

    typedef struct {
        logic [79:0] bytes;
        int          n;
        bit          good;
        bit          bad;
        logic [7:0]  code;
        logic [31:0] data;
    } vec_t;

    vec_t vt [6];
    logic [7:0]  exp_code = 8'd0;
    logic [31:0] exp_data = 32'd0;
    int exp_err = 0;

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b_valid, b_chk, b_to, r, r2;

        vt[0] = '{80'hEB_90_05_11_22_33_44_AF_00_00, 8, 1'b1, 1'b0, 8'h05, 32'h11223344};
        vt[1] = '{80'hEB_90_05_11_22_33_44_AE_00_00, 8, 1'b0, 1'b1, 8'h00, 32'h0};
        vt[2] = '{80'hEB_90_A5_DE_AD_BE_EF_DD_00_00, 8, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF};
        vt[3] = '{80'h00_EB_EB_90_01_00_00_00_02_03, 10, 1'b1, 1'b0, 8'h01, 32'h00000002};
        vt[4] = '{80'hEB_90_07_EB_90_EB_90_FD_00_00, 8, 1'b1, 1'b0, 8'h07, 32'hEB90EB90};
        vt[5] = '{80'hEB_12_EB_90_02_00_00_00_00_02, 10, 1'b1, 1'b0, 8'h02, 32'h00000000};

        // Reset state, with a byte waiting so the read strobe gate is exercised.
        rst = 1'b0;
        repeat (3) step();
        push(8'h55);
        #1;
        check("reset ren", 64'(rx_fifo_ren), 64'd0);
        check("reset outputs", {cmd_valid, cmd_code, cmd_data, chk_err, to_err, err_cnt, busy},
              64'd0);
        step();
        rst = 1'b1;
        drain("reset");
        check("reset junk byte", {32'(n_valid), 32'(n_chk + n_to)}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            b_valid = n_valid;
            b_chk   = n_chk;
            b_to    = n_to;
            for (int j = 0; j < vt[i].n; j++) push(vt[i].bytes[79 - 8 * j -: 8]);
            drain($sformatf("v%0d", i));
            if (vt[i].good) begin
                exp_code = vt[i].code;
                exp_data = vt[i].data;
            end
            if (vt[i].bad) exp_err = sat_inc(exp_err);
            check($sformatf("v%0d valid pulses", i), 64'(n_valid - b_valid), 64'(vt[i].good));
            check($sformatf("v%0d chk_err pulses", i), 64'(n_chk - b_chk), 64'(vt[i].bad));
            check($sformatf("v%0d to_err pulses", i), 64'(n_to - b_to), 64'd0);
            check($sformatf("v%0d cmd_code", i), 64'(cmd_code), 64'(exp_code));
            check($sformatf("v%0d cmd_data", i), 64'(cmd_data), 64'(exp_data));
            check($sformatf("v%0d err_cnt", i), 64'(err_cnt), 64'(exp_err));
            check($sformatf("v%0d busy", i), 64'(busy), 64'd0);
            if (vt[i].good)
                check($sformatf("v%0d strobe-time code/data", i), {24'd0, v_code, v_data},
                      {24'd0, vt[i].code, vt[i].data});
        end

        // Timeout: header, cmd, one data byte, then nothing.
        b_to = n_to;
        push(8'hEB); push(8'h90); push(8'h05); push(8'h11);
        drain("to1");
        r = last_ren_cyc;
        check("to1 busy mid-frame", 64'(busy), 64'd1);
        while (cyc < r + 1 + int'(TO) + 3) step();
        exp_err = sat_inc(exp_err);
        check("to1 to_err pulses", 64'(n_to - b_to), 64'd1);
        check("to1 to_err latency", 64'(to_cyc - (r + 1)), 64'(TO));
        check("to1 err_cnt", 64'(err_cnt), 64'(exp_err));
        check("to1 busy", 64'(busy), 64'd0);

        // Next byte's byte_vld lands exactly on the terminal count: byte wins.
        b_to    = n_to;
        b_valid = n_valid;
        push(8'hEB); push(8'h90); push(8'h05); push(8'h11);
        drain("to2");
        r = last_ren_cyc;
        while (cyc < r + int'(TO) - 1) step();
        push(8'h22);
        step();
        r2 = last_ren_cyc;
        check("to2 late read cycle", 64'(r2 - r), 64'(TO - 1));
        repeat (3) step();
        push(8'h33); push(8'h44); push(8'hAF);
        drain("to2 tail");
        exp_code = 8'h05;
        exp_data = 32'h11223344;
        check("to2 no to_err", 64'(n_to - b_to), 64'd0);
        check("to2 valid pulses", 64'(n_valid - b_valid), 64'd1);
        check("to2 code/data", {24'd0, cmd_code, cmd_data}, {24'd0, exp_code, exp_data});
        check("to2 err_cnt", 64'(err_cnt), 64'(exp_err));

        // Saturation: 300 bad-checksum frames.
        b_chk   = n_chk;
        b_valid = n_valid;
        for (int f = 0; f < 300; f++) begin
            push(8'hEB); push(8'h90);
            for (int j = 0; j < 5; j++) push(8'h00);
            push(8'h01);
            drain("sat");
            exp_err = sat_inc(exp_err);
        end
        check("sat chk_err pulses", 64'(n_chk - b_chk), 64'd300);
        check("sat no valid", 64'(n_valid - b_valid), 64'd0);
        check("sat err_cnt", 64'(err_cnt), 64'(exp_err));
        check("sat err_cnt 255", 64'(err_cnt), 64'd255);
        check("sat code/data held", {24'd0, cmd_code, cmd_data}, {24'd0, exp_code, exp_data});

        // Reset mid-frame with a read in flight.
        push(8'hEB); push(8'h90); push(8'h05);
        drain("rst");
        check("rst busy before", 64'(busy), 64'd1);
        push(8'h11);
        step();
        rst = 1'b0;
        #1;
        check("rst mid outputs", {rx_fifo_ren, cmd_valid, cmd_code, cmd_data, chk_err, to_err,
              err_cnt, busy}, 64'd0);
        repeat (2) step();
        rst = 1'b1;
        b_valid = n_valid;
        b_chk   = n_chk;
        b_to    = n_to;
        push(8'hEB); push(8'h90); push(8'h3C);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h46);
        drain("rst after");
        check("rst after valid", 64'(n_valid - b_valid), 64'd1);
        check("rst after code/data", {24'd0, cmd_code, cmd_data}, {24'd0, 8'h3C, 32'h01020304});
        check("rst after errs", {32'(n_chk - b_chk), 32'(n_to - b_to)}, 64'd0);
        check("rst after err_cnt", 64'(err_cnt), 64'd0);

        check("handshake violations", 64'(hs_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
